prf_mp: RTL and testbench
=========================

// Module: prf_mp
// PURPOSE
//  Multi-ported physical register file with per-entry ready bits. Serves the issue stage with
//  NUM_RD source-operand pairs, accepts NUM_CDB writeback lanes, and marks newly renamed
//  destinations not-ready. Supports mispredict recovery via a ready-set mask and reports
//  same-cycle CDB collisions. Sits between rename/dispatch, the reservation stations and the CDB.
// PARAMETERS
//  XLEN     32  data width
//  NUM_RD   2   read-port pairs (rs1/rs2 each); total read ports NR = 2*NUM_RD
//  NUM_CDB  2   CDB writeback lanes
//  NUM_ALOC 1   allocation (dispatch) lanes
//  NUMP     rv32i_types::NUM_PHYS_REG   entries; PW = rv32i_types::PHYS_REG_IDX+1 index width
// PORTS
//  clk          in   1              clock
//  rst          in   1              reset, asynchronous, active-high
//  rd_pid       in   [NR] x PW      read-port physical index
//  rd_data      out  [NR] x XLEN    read data, CDB-bypassed
//  rd_ready     out  [NR] x 1       operand ready, CDB-bypassed
//  alloc_valid  in   [NUM_ALOC] x 1 allocate lane valid
//  alloc_pid    in   [NUM_ALOC] x PW pid to mark not-ready
//  cdb_valid    in   [NUM_CDB] x 1  writeback lane valid
//  cdb_pid      in   [NUM_CDB] x PW writeback pid
//  cdb_value    in   [NUM_CDB] x XLEN writeback data
//  flush_valid  in   1              mispredict recovery strobe
//  flush_rdy    in   NUMP           pids to force ready on flush
//  coll_cnt     out  8              saturating count of CDB collision cycles
//  coll_err     out  1              sticky: any collision seen since reset
// BEHAVIOUR
//  - Reset (async): rf[*]=0; ready[0]=1, ready[1..NUMP-1]=0; coll_cnt=0, coll_err=0.
//    Outputs derived combinationally from state; after reset rd_ready=1 only for pid 0.
//  - pid 0: rd_data=0, rd_ready=1 always; CDB writes, allocs, flush to pid 0 ignored.
//  - Read (comb, 0-cycle): rd_data=rf[pid], rd_ready=ready[pid]; if any valid CDB lane
//    matches pid (!=0), rd_data=that lane's value, rd_ready=1. Multiple matches: highest lane wins.
//  - CDB write (posedge): for each valid lane, rf[pid]<=value, ready[pid]<=1; lanes applied in
//    ascending order (highest lane wins on collision).
//  - Alloc (posedge): ready[alloc_pid]<=0. Priority per entry: alloc > flush > CDB
//    (alloc to a pid being written in same cycle leaves it not-ready; data still written).
//  - Flush: ready[i]<=1 for every i with flush_rdy[i]; rf unchanged.
//  - Collision: cycle with >=2 valid lanes on same nonzero pid -> coll_cnt+=1 (saturate at 255),
//    coll_err<=1 (sticky until reset).
//  - Reset asserted mid-operation: state cleared immediately; in-flight writes lost.
// CONFIGURATION
//  PRF_READ_PIPE_EN defined: reads are 1-cycle registered. rd_pid sampled at posedge N;
//    rd_data/rd_ready valid during cycle N+1 from rf/ready state, plus bypass from CDB lanes
//    valid in cycle N+1 on the registered pid. Registered pid resets to 0 (out: data 0, ready 1).
//  Undefined: 0-cycle combinational read as above.
// STRUCTURE
//  rv32i_types: PHYS_REG_IDX, NUM_PHYS_REG, typedef cdb_lane_t {valid; pid; value}.
//  Sub-module prf_rd_port: one read port (index mux + CDB bypass + optional pid register),
//    instantiated NR times. Top holds rf/ready arrays, write/alloc/flush logic, collision counter.
// TESTING
//  1 reset then read pids 0,5 -> data 0/0, ready 1/0; coll_cnt=0.
//  2 cdb lane0 pid 5 val 0xDEAD_BEEF while rd_pid=5 -> same cycle data 0xDEADBEEF ready 1;
//    next cycle (no CDB) still 0xDEADBEEF ready 1.
//  3 alloc pid 7 and cdb lane1 pid 7 val 0x11 same cycle -> next cycle ready 0, data 0x11.
//  4 lanes 0,1 both pid 9 vals 0xA,0xB -> bypass 0xB; rf[9]=0xB; coll_cnt=1, coll_err=1;
//    repeat 300 cycles -> coll_cnt=255.
//  5 alloc pids 3,4; flush_valid with flush_rdy bit 3 -> ready[3]=1, ready[4]=0.
//  6 cdb write pid 0 val 0x55 -> rd pid 0 still 0; with PRF_READ_PIPE_EN rerun 2 expecting
//    1-cycle latency.

Source files
------------

// File: rtl/prf_mp_pkg.sv
// Shared types and sizing for the physical register file slice.
// Build option: PRF_READ_PIPE_EN (see prf_rd_port) selects registered reads.
package rv32i_types;

  localparam int unsigned PHYS_REG_IDX = 5;
  localparam int unsigned NUM_PHYS_REG = 64;
  localparam int unsigned DATA_W       = 32;

  typedef struct packed {
    logic                  valid;
    logic [PHYS_REG_IDX:0] pid;
    logic [DATA_W-1:0]     value;
  } cdb_lane_t;

  // pid 0 is the hard-wired zero register and never tracked
  function automatic logic pid_live(input logic [PHYS_REG_IDX:0] pid);
    return pid != '0;
  endfunction

endpackage

// File: rtl/prf_mp_rd_port.sv
// One PRF read port: index mux over rf/ready plus CDB bypass.
// Build option: PRF_READ_PIPE_EN registers the incoming pid so the port
// returns data one cycle after sampling; the bypass then uses the
// registered pid against the CDB lanes of the current cycle.
module prf_rd_port
  import rv32i_types::*;
#(
  parameter int unsigned XLEN    = DATA_W,
  parameter int unsigned NUMP    = NUM_PHYS_REG,
  parameter int unsigned PW      = PHYS_REG_IDX + 1,
  parameter int unsigned NUM_CDB = 2
)(
`ifdef PRF_READ_PIPE_EN
  input  logic               i_clk,
  input  logic               i_rst,
`endif
  input  logic [PW-1:0]      i_pid,
  input  logic [XLEN-1:0]    i_rf        [NUMP],
  input  logic [NUMP-1:0]    i_ready,
  input  logic [NUM_CDB-1:0] i_cdb_valid,
  input  logic [PW-1:0]      i_cdb_pid   [NUM_CDB],
  input  logic [XLEN-1:0]    i_cdb_value [NUM_CDB],
  output logic [XLEN-1:0]    o_data,
  output logic               o_ready
);

  logic [PW-1:0] w_pid;

`ifdef PRF_READ_PIPE_EN
  logic [PW-1:0] r_pid;

  // sample the requested pid; reset points the port at the zero register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_pid <= '0;
    else       r_pid <= i_pid;
  end

  assign w_pid = r_pid;
`else
  assign w_pid = i_pid;
`endif

  // storage lookup, overridden by matching CDB lanes (highest lane last wins)
  always_comb begin
    o_data  = i_rf[w_pid];
    o_ready = i_ready[w_pid];
    for (int unsigned l = 0; l < NUM_CDB; l++) begin
      if (i_cdb_valid[l] && (i_cdb_pid[l] == w_pid)) begin
        o_data  = i_cdb_value[l];
        o_ready = 1'b1;
      end
    end
    if (!pid_live(w_pid)) begin
      o_data  = '0;
      o_ready = 1'b1;
    end
  end

endmodule

// File: rtl/prf_mp.sv
// Multi-ported physical register file with per-entry ready bits,
// CDB writeback, dispatch allocation, flush recovery and CDB collision
// reporting. Build option: PRF_READ_PIPE_EN (registered read ports).
module prf_mp
  import rv32i_types::*;
#(
  parameter int unsigned XLEN     = DATA_W,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_CDB  = 2,
  parameter int unsigned NUM_ALOC = 1,
  parameter int unsigned NUMP     = NUM_PHYS_REG,
  parameter int unsigned PW       = PHYS_REG_IDX + 1,
  localparam int unsigned NR      = 2 * NUM_RD
)(
  input  logic                clk,
  input  logic                rst,
  input  logic [PW-1:0]       rd_pid      [NR],
  output logic [XLEN-1:0]     rd_data     [NR],
  output logic [NR-1:0]       rd_ready,
  input  logic [NUM_ALOC-1:0] alloc_valid,
  input  logic [PW-1:0]       alloc_pid   [NUM_ALOC],
  input  logic [NUM_CDB-1:0]  cdb_valid,
  input  logic [PW-1:0]       cdb_pid     [NUM_CDB],
  input  logic [XLEN-1:0]     cdb_value   [NUM_CDB],
  input  logic                flush_valid,
  input  logic [NUMP-1:0]     flush_rdy,
  output logic [7:0]          coll_cnt,
  output logic                coll_err
);

  logic [XLEN-1:0] r_rf [NUMP];
  logic [NUMP-1:0] r_ready;
  logic [7:0]      r_coll_cnt;
  logic            r_coll_err;
  cdb_lane_t       w_cdb [NUM_CDB];
  logic            w_coll;

  // bundle the CDB inputs into lane records
  always_comb begin
    for (int unsigned l = 0; l < NUM_CDB; l++) begin
      w_cdb[l].valid = cdb_valid[l];
      w_cdb[l].pid   = cdb_pid[l];
      w_cdb[l].value = cdb_value[l];
    end
  end

  // detect two or more valid lanes targeting the same live pid
  always_comb begin
    w_coll = 1'b0;
    for (int unsigned a = 0; a < NUM_CDB; a++) begin
      for (int unsigned b = a + 1; b < NUM_CDB; b++) begin
        if (w_cdb[a].valid && w_cdb[b].valid &&
            (w_cdb[a].pid == w_cdb[b].pid) && pid_live(w_cdb[a].pid))
          w_coll = 1'b1;
      end
    end
  end

  // data array: lanes in ascending order so the highest lane lands last
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUMP; i++) r_rf[i] <= '0;
    end else begin
      for (int unsigned l = 0; l < NUM_CDB; l++) begin
        if (w_cdb[l].valid && pid_live(w_cdb[l].pid))
          r_rf[w_cdb[l].pid] <= w_cdb[l].value;
      end
    end
  end

  // ready bits: CDB, then flush, then alloc; later assignments take priority
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ready <= NUMP'(1);
    end else begin
      for (int unsigned l = 0; l < NUM_CDB; l++) begin
        if (w_cdb[l].valid && pid_live(w_cdb[l].pid))
          r_ready[w_cdb[l].pid] <= 1'b1;
      end
      for (int unsigned i = 0; i < NUMP; i++) begin
        if (flush_valid && flush_rdy[i] && (i != 0))
          r_ready[i] <= 1'b1;
      end
      for (int unsigned a = 0; a < NUM_ALOC; a++) begin
        if (alloc_valid[a] && pid_live(alloc_pid[a]))
          r_ready[alloc_pid[a]] <= 1'b0;
      end
    end
  end

  // saturating collision counter and sticky error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_coll_cnt <= '0;
      r_coll_err <= 1'b0;
    end else if (w_coll) begin
      if (r_coll_cnt != '1) r_coll_cnt <= r_coll_cnt + 8'd1;
      r_coll_err <= 1'b1;
    end
  end

  assign coll_cnt = r_coll_cnt;
  assign coll_err = r_coll_err;

  for (genvar p = 0; p < NR; p++) begin : g_rd
    prf_rd_port #(
      .XLEN    (XLEN),
      .NUMP    (NUMP),
      .PW      (PW),
      .NUM_CDB (NUM_CDB)
    ) u_rd (
`ifdef PRF_READ_PIPE_EN
      .i_clk       (clk),
      .i_rst       (rst),
`endif
      .i_pid       (rd_pid[p]),
      .i_rf        (r_rf),
      .i_ready     (r_ready),
      .i_cdb_valid (cdb_valid),
      .i_cdb_pid   (cdb_pid),
      .i_cdb_value (cdb_value),
      .o_data      (rd_data[p]),
      .o_ready     (rd_ready[p])
    );
  end

endmodule

// File: tb/tb_prf_mp.sv
// Self-checking bench for prf_mp: directed scenarios plus randomized
// traffic against an array-based reference model of the register file.
module tb_prf_mp;
  import rv32i_types::*;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NUM_RD = 2;
  localparam int unsigned NR = 2 * NUM_RD;
  localparam int unsigned NUM_CDB = 2;
  localparam int unsigned NUM_ALOC = 1;
  localparam int unsigned NUMP = NUM_PHYS_REG;
  localparam int unsigned PW = PHYS_REG_IDX + 1;
`ifdef PRF_READ_PIPE_EN
  localparam bit PIPE = 1'b1;
`else
  localparam bit PIPE = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic [PW-1:0]       rd_pid    [NR];
  logic [XLEN-1:0]     rd_data   [NR];
  logic [NR-1:0]       rd_ready;
  logic [NUM_ALOC-1:0] alloc_valid;
  logic [PW-1:0]       alloc_pid [NUM_ALOC];
  logic [NUM_CDB-1:0]  cdb_valid;
  logic [PW-1:0]       cdb_pid   [NUM_CDB];
  logic [XLEN-1:0]     cdb_value [NUM_CDB];
  logic                flush_valid;
  logic [NUMP-1:0]     flush_rdy;
  logic [7:0]          coll_cnt;
  logic                coll_err;

  int total = 0;
  int bad = 0;

  // reference model state
  logic [XLEN-1:0] m_rf    [NUMP];
  bit              m_ready [NUMP];
  int              m_cnt;
  bit              m_err;
  logic [PW-1:0]   m_rpid  [NR];

  prf_mp #(
    .XLEN     (XLEN),
    .NUM_RD   (NUM_RD),
    .NUM_CDB  (NUM_CDB),
    .NUM_ALOC (NUM_ALOC),
    .NUMP     (NUMP),
    .PW       (PW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rd_pid      (rd_pid),
    .rd_data     (rd_data),
    .rd_ready    (rd_ready),
    .alloc_valid (alloc_valid),
    .alloc_pid   (alloc_pid),
    .cdb_valid   (cdb_valid),
    .cdb_pid     (cdb_pid),
    .cdb_value   (cdb_value),
    .flush_valid (flush_valid),
    .flush_rdy   (flush_rdy),
    .coll_cnt    (coll_cnt),
    .coll_err    (coll_err)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    alloc_valid = '0;
    cdb_valid   = '0;
    flush_valid = 1'b0;
    flush_rdy   = '0;
    for (int a = 0; a < NUM_ALOC; a++) alloc_pid[a] = '0;
    for (int l = 0; l < NUM_CDB; l++) begin
      cdb_pid[l]   = '0;
      cdb_value[l] = '0;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUMP; i++) begin
      m_rf[i]    = '0;
      m_ready[i] = (i == 0);
    end
    for (int p = 0; p < NR; p++) m_rpid[p] = '0;
    m_cnt = 0;
    m_err = 0;
  endtask

  // apply one clock edge worth of architectural rules to the model
  task automatic model_edge();
    int hits [NUMP];
    bit coll;
    for (int i = 0; i < NUMP; i++) hits[i] = 0;
    for (int l = 0; l < NUM_CDB; l++) begin
      if (cdb_valid[l] && cdb_pid[l] != 0) begin
        m_rf[cdb_pid[l]]    = cdb_value[l];
        m_ready[cdb_pid[l]] = 1;
        hits[cdb_pid[l]]++;
      end
    end
    if (flush_valid)
      for (int i = 1; i < NUMP; i++) if (flush_rdy[i]) m_ready[i] = 1;
    for (int a = 0; a < NUM_ALOC; a++)
      if (alloc_valid[a] && alloc_pid[a] != 0) m_ready[alloc_pid[a]] = 0;
    coll = 0;
    for (int i = 1; i < NUMP; i++) if (hits[i] >= 2) coll = 1;
    if (coll) begin
      if (m_cnt < 255) m_cnt++;
      m_err = 1;
    end
    for (int p = 0; p < NR; p++) m_rpid[p] = rd_pid[p];
  endtask

  task automatic tick();
    if (!rst) model_edge();
    @(posedge clk);
    #1;
  endtask

  function automatic void exp_rd(input int p, output logic [XLEN-1:0] d, output logic r);
    logic [PW-1:0] pid;
    pid = PIPE ? m_rpid[p] : rd_pid[p];
    if (pid == 0) begin
      d = '0;
      r = 1'b1;
    end else begin
      d = m_rf[pid];
      r = m_ready[pid];
      for (int l = 0; l < NUM_CDB; l++) begin
        if (cdb_valid[l] && cdb_pid[l] == pid) begin
          d = cdb_value[l];
          r = 1'b1;
        end
      end
    end
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    for (int p = 0; p < NR; p++) rd_pid[p] = '0;
    rd_pid[1] = 6'd5;
    do_reset();
    total++;
    if (coll_cnt !== 8'd0 || coll_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_coll: cnt=%0d err=%0b required 0/0", coll_cnt, coll_err);
    end
    tick();
    total++;
    if (rd_data[0] !== 32'd0 || rd_ready[0] !== 1'b1) begin
      bad++;
      $display("FAIL reset_pid0: data=%h rdy=%b required 0/1", rd_data[0], rd_ready[0]);
    end
    total++;
    if (rd_data[1] !== 32'd0 || rd_ready[1] !== 1'b0) begin
      bad++;
      $display("FAIL reset_pid5: data=%h rdy=%b required 0/0", rd_data[1], rd_ready[1]);
    end
  endtask

  task automatic test_bypass();
    logic [XLEN-1:0] exp_now;
    rd_pid[0] = 6'd5;
    rd_pid[2] = 6'd0;
    tick();
    cdb_valid[0] = 1'b1;
    cdb_pid[0]   = 6'd5;
    cdb_value[0] = 32'hDEAD_BEEF;
    #1;
    total++;
    if (rd_data[0] !== 32'hDEAD_BEEF || rd_ready[0] !== 1'b1) begin
      bad++;
      $display("FAIL bypass_same: data=%h rdy=%b required deadbeef/1", rd_data[0], rd_ready[0]);
    end
    tick();
    clear_inputs();
    #1;
    total++;
    if (rd_data[0] !== 32'hDEAD_BEEF || rd_ready[0] !== 1'b1) begin
      bad++;
      $display("FAIL bypass_next: data=%h rdy=%b required deadbeef/1", rd_data[0], rd_ready[0]);
    end
    // read latency: a fresh pid shows up immediately, or one edge later when registered
    rd_pid[2] = 6'd5;
    #1;
    exp_now = PIPE ? 32'd0 : 32'hDEAD_BEEF;
    total++;
    if (rd_data[2] !== exp_now) begin
      bad++;
      $display("FAIL read_latency_now: data=%h required %h", rd_data[2], exp_now);
    end
    tick();
    total++;
    if (rd_data[2] !== 32'hDEAD_BEEF || rd_ready[2] !== 1'b1) begin
      bad++;
      $display("FAIL read_latency_next: data=%h rdy=%b required deadbeef/1", rd_data[2], rd_ready[2]);
    end
  endtask

  task automatic test_alloc_vs_cdb();
    rd_pid[0] = 6'd7;
    tick();
    alloc_valid[0] = 1'b1;
    alloc_pid[0]   = 6'd7;
    cdb_valid[1]   = 1'b1;
    cdb_pid[1]     = 6'd7;
    cdb_value[1]   = 32'h11;
    tick();
    clear_inputs();
    #1;
    total++;
    if (rd_data[0] !== 32'h11 || rd_ready[0] !== 1'b0) begin
      bad++;
      $display("FAIL alloc_beats_cdb: data=%h rdy=%b required 11/0", rd_data[0], rd_ready[0]);
    end
  endtask

  task automatic test_collision();
    rd_pid[0] = 6'd9;
    tick();
    cdb_valid = 2'b11;
    cdb_pid[0] = 6'd9; cdb_value[0] = 32'hA;
    cdb_pid[1] = 6'd9; cdb_value[1] = 32'hB;
    #1;
    total++;
    if (rd_data[0] !== 32'hB || rd_ready[0] !== 1'b1) begin
      bad++;
      $display("FAIL coll_bypass: data=%h rdy=%b required b/1", rd_data[0], rd_ready[0]);
    end
    tick();
    clear_inputs();
    #1;
    total++;
    if (rd_data[0] !== 32'hB || coll_cnt !== 8'd1 || coll_err !== 1'b1) begin
      bad++;
      $display("FAIL coll_once: data=%h cnt=%0d err=%b required b/1/1", rd_data[0], coll_cnt, coll_err);
    end
    cdb_valid = 2'b11;
    cdb_pid[0] = 6'd9; cdb_pid[1] = 6'd9;
    repeat (300) tick();
    clear_inputs();
    #1;
    total++;
    if (coll_cnt !== 8'd255 || coll_err !== 1'b1) begin
      bad++;
      $display("FAIL coll_saturate: cnt=%0d err=%b required 255/1", coll_cnt, coll_err);
    end
  endtask

  task automatic test_flush();
    cdb_valid = 2'b11;
    cdb_pid[0] = 6'd3; cdb_value[0] = 32'h3333;
    cdb_pid[1] = 6'd4; cdb_value[1] = 32'h4444;
    rd_pid[0] = 6'd3;
    rd_pid[1] = 6'd4;
    tick();
    clear_inputs();
    alloc_valid[0] = 1'b1; alloc_pid[0] = 6'd3;
    tick();
    alloc_pid[0] = 6'd4;
    tick();
    clear_inputs();
    #1;
    total++;
    if (rd_ready[0] !== 1'b0 || rd_ready[1] !== 1'b0) begin
      bad++;
      $display("FAIL alloc_not_ready: rdy3=%b rdy4=%b required 0/0", rd_ready[0], rd_ready[1]);
    end
    flush_valid = 1'b1;
    flush_rdy   = '0;
    flush_rdy[3] = 1'b1;
    tick();
    clear_inputs();
    #1;
    total++;
    if (rd_ready[0] !== 1'b1 || rd_ready[1] !== 1'b0 || rd_data[0] !== 32'h3333) begin
      bad++;
      $display("FAIL flush_mask: rdy3=%b rdy4=%b data3=%h required 1/0/3333",
               rd_ready[0], rd_ready[1], rd_data[0]);
    end
  endtask

  task automatic test_pid0();
    rd_pid[0] = 6'd0;
    tick();
    cdb_valid[0] = 1'b1; cdb_pid[0] = 6'd0; cdb_value[0] = 32'h55;
    alloc_valid[0] = 1'b1; alloc_pid[0] = 6'd0;
    #1;
    total++;
    if (rd_data[0] !== 32'd0 || rd_ready[0] !== 1'b1) begin
      bad++;
      $display("FAIL pid0_same: data=%h rdy=%b required 0/1", rd_data[0], rd_ready[0]);
    end
    tick();
    clear_inputs();
    #1;
    total++;
    if (rd_data[0] !== 32'd0 || rd_ready[0] !== 1'b1) begin
      bad++;
      $display("FAIL pid0_next: data=%h rdy=%b required 0/1", rd_data[0], rd_ready[0]);
    end
  endtask

  task automatic test_random();
    logic [XLEN-1:0] ed;
    logic            er;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int p = 0; p < NR; p++) rd_pid[p] = PW'($urandom_range(0, 15));
      for (int l = 0; l < NUM_CDB; l++) begin
        cdb_valid[l] = ($urandom_range(0, 1) == 1);
        cdb_pid[l]   = PW'($urandom_range(0, 15));
        cdb_value[l] = $urandom;
      end
      alloc_valid[0] = ($urandom_range(0, 2) == 0);
      alloc_pid[0]   = PW'($urandom_range(0, 15));
      flush_valid    = ($urandom_range(0, 7) == 0);
      flush_rdy      = {$urandom, $urandom};
      if (cyc == 200) begin
        // asynchronous reset in the middle of a cycle with traffic present
        #2;
        rst = 1'b1;
        model_reset();
      end
      #1;
      for (int p = 0; p < NR; p++) begin
        exp_rd(p, ed, er);
        total++;
        if (rd_data[p] !== ed || rd_ready[p] !== er) begin
          bad++;
          $display("FAIL rand_read c%0d p%0d pid=%0d: data=%h rdy=%b required %h/%b",
                   cyc, p, rd_pid[p], rd_data[p], rd_ready[p], ed, er);
        end
      end
      total++;
      if (coll_cnt !== 8'(m_cnt) || coll_err !== m_err) begin
        bad++;
        $display("FAIL rand_coll c%0d: cnt=%0d err=%b required %0d/%b",
                 cyc, coll_cnt, coll_err, m_cnt, m_err);
      end
      tick();
      if (rst) rst = 1'b0;
    end
    clear_inputs();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    for (int p = 0; p < NR; p++) rd_pid[p] = '0;
    test_reset();
    test_bypass();
    test_alloc_vs_cdb();
    test_collision();
    test_flush();
    test_pid0();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
